// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Holds field layout of an instruction word, FSM encoding and the retire-counter helper.
package instruction_fetch_unit_pkg;

    localparam int unsigned AB  = 11;
    localparam int unsigned OPB = 5;
    localparam int unsigned IW  = OPB + AB;
    localparam int unsigned RW  = 16;

    localparam logic [OPB-1:0] OPC_HALT = OPB'(0);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LATCH = 3'd2,
        ST_EXEC  = 3'd3,
        ST_HALT  = 3'd4
    } fetch_state_t;

    // Instruction word layout: opcode in the top bits, operand below.
    typedef struct packed {
        logic [OPB-1:0] opcode;
        logic [AB-1:0]  operand;
    } instr_t;

    function automatic logic is_halt(input instr_t word);
        return word.opcode == OPC_HALT;
    endfunction

    function automatic logic [RW-1:0] sat_inc(input logic [RW-1:0] value);
        return (value == {RW{1'b1}}) ? value : value + RW'(1);
    endfunction

endpackage

// File: rtl/instruction_fetch_unit.sv
// Fetch stage ahead of the CPU control block: reads the program ROM at the PC,
// presents each instruction for one execute cycle, strobes the PC and stops on HALT.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run,
    input  logic [AB-1:0]       pc_addr,
    output logic                rom_en,
    output logic [AB-1:0]       rom_addr,
    input  logic [IW-1:0]       rom_data,
    output logic [OPB-1:0]      opcode,
    output logic [AB-1:0]       operand,
    output logic                instr_valid,
    output logic                pc_wr,
    output logic                halted,
    output logic [RW-1:0]       retired
);

    fetch_state_t state_q;
    fetch_state_t state_d;

    instr_t        instr_q;
    instr_t        rom_word;
    logic [AB-1:0] addr_q;

    logic addr_en;
    logic latch_en;
    logic retire;
    logic rom_en_d;
    logic valid_d;
    logic pc_wr_d;
    logic halted_d;

    assign rom_word = instr_t'(rom_data);

    // Next state plus next values of the registered strobes.
    always_comb begin
        state_d  = state_q;
        addr_en  = 1'b0;
        latch_en = 1'b0;
        retire   = 1'b0;
        rom_en_d = 1'b0;
        valid_d  = 1'b0;
        pc_wr_d  = 1'b0;
        halted_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                addr_en = 1'b1;
                state_d = ST_LATCH;
            end
            ST_LATCH: begin
                latch_en = 1'b1;
                state_d  = ST_EXEC;
            end
            ST_EXEC: begin
                retire = 1'b1;
                if (is_halt(instr_q)) begin
                    state_d = ST_HALT;
                end else if (run) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Strobes are registered, so they are decoded from the state being entered.
        rom_en_d = (state_d == ST_FETCH);
        valid_d  = (state_d == ST_EXEC);
        pc_wr_d  = (state_d == ST_EXEC) && latch_en && !is_halt(rom_word);
        halted_d = (state_d == ST_HALT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rom_en      <= 1'b0;
            instr_valid <= 1'b0;
            pc_wr       <= 1'b0;
            halted      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rom_en      <= rom_en_d;
            instr_valid <= valid_d;
            pc_wr       <= pc_wr_d;
            halted      <= halted_d;
        end
    end

    // Instruction word and fetch address, both held until overwritten.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q <= '0;
            addr_q  <= '0;
        end else begin
            if (latch_en) begin
                instr_q <= rom_word;
            end
            if (addr_en) begin
                addr_q <= pc_addr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired <= '0;
        end else if (retire) begin
            retired <= sat_inc(retired);
        end
    end

    // The PC only settles at the end of EXEC, so the ROM sees the live PC during FETCH.
    assign rom_addr = rom_en ? pc_addr : addr_q;
    assign opcode   = instr_q.opcode;
    assign operand  = instr_q.operand;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios plus random
// programs and run patterns, checked against a transaction-level fetch/execute model.
module tb_instruction_fetch_unit;
    import instruction_fetch_unit_pkg::*;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            run = 1'b0;
    logic [AB-1:0]   pc_addr = '0;
    logic            rom_en;
    logic [AB-1:0]   rom_addr;
    logic [IW-1:0]   rom_data = '0;
    logic [OPB-1:0]  opcode;
    logic [AB-1:0]   operand;
    logic            instr_valid;
    logic            pc_wr;
    logic            halted;
    logic [RW-1:0]   retired;

    logic            pc_load = 1'b0;
    logic [AB-1:0]   pc_load_val = '0;
    logic            scramble = 1'b0;
    logic [IW-1:0]   mem [0:(1<<AB)-1];

    int              n_checks = 0;
    int              n_fail = 0;

    int unsigned     exp_ret = 0;
    bit              exp_halt = 1'b0;
    bit              en_d1 = 1'b0;
    bit              en_d2 = 1'b0;

    always #5 clk = ~clk;

    instruction_fetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .pc_addr     (pc_addr),
        .rom_en      (rom_en),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .opcode      (opcode),
        .operand     (operand),
        .instr_valid (instr_valid),
        .pc_wr       (pc_wr),
        .halted      (halted),
        .retired     (retired)
    );

    // Environment: PC register of the control block and a synchronous ROM.
    always @(posedge clk) begin
        if (pc_load)    pc_addr <= pc_load_val;
        else if (pc_wr) pc_addr <= AB'(pc_addr + 1'b1);
    end

    always @(posedge clk) begin
        if (rom_en)        rom_data <= mem[rom_addr];
        else if (scramble) rom_data <= IW'($urandom);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference rules: an instruction executes two cycles after its ROM read,
    // executes the word at the current PC, and each execute retires one instruction.
    task automatic monitor();
        logic [IW-1:0] w;
        check("retired", 32'(retired), exp_ret);
        check("halted", 32'(halted), 32'(exp_halt));
        check("valid_after_fetch", 32'(instr_valid), 32'(en_d2));
        if (rom_en) begin
            check("fetch_addr", 32'(rom_addr), 32'(pc_addr));
            check("fetch_spacing", 32'(en_d1 | en_d2), 32'(0));
        end
        if (exp_halt) begin
            check("halt_rom_en", 32'(rom_en), 32'(0));
            check("halt_pc_wr", 32'(pc_wr), 32'(0));
            check("halt_valid", 32'(instr_valid), 32'(0));
        end
        if (instr_valid) begin
            w = mem[pc_addr];
            check("exec_opcode", 32'(opcode), 32'(w[IW-1:AB]));
            check("exec_operand", 32'(operand), 32'(w[AB-1:0]));
            check("exec_pc_wr", 32'(pc_wr), 32'(w[IW-1:AB] != 0));
            check("exec_rom_addr", 32'(rom_addr), 32'(pc_addr));
            exp_ret = (exp_ret >= 32'hFFFF) ? 32'hFFFF : exp_ret + 1;
            if (w[IW-1:AB] == 0) exp_halt = 1'b1;
        end else begin
            check("pc_wr_outside_exec", 32'(pc_wr), 32'(0));
        end
        en_d2 = en_d1;
        en_d1 = rom_en;
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        run   = 1'b0;
        #1;
        check("rst_rom_en", 32'(rom_en), 32'(0));
        check("rst_rom_addr", 32'(rom_addr), 32'(0));
        check("rst_opcode", 32'(opcode), 32'(0));
        check("rst_operand", 32'(operand), 32'(0));
        check("rst_valid", 32'(instr_valid), 32'(0));
        check("rst_pc_wr", 32'(pc_wr), 32'(0));
        check("rst_halted", 32'(halted), 32'(0));
        check("rst_retired", 32'(retired), 32'(0));
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        exp_ret  = 0;
        exp_halt = 1'b0;
        en_d1    = 1'b0;
        en_d2    = 1'b0;
    endtask

    task automatic load_pc(input logic [AB-1:0] value);
        pc_load     = 1'b1;
        pc_load_val = value;
        tick();
        pc_load     = 1'b0;
    endtask

    initial begin
        logic [OPB-1:0] op;
        int exp_ops [3];
        int exp_opr [3];
        exp_ops = '{1, 2, 0};
        exp_opr = '{0, 5, 0};

        for (int i = 0; i < (1 << AB); i++) begin
            mem[i] = {OPB'(1 + (i % 31)), AB'(i)};
        end

        #1;
        do_reset();

        // Three-word program ending in HALT
        mem[0] = 16'h0800;
        mem[1] = 16'h1005;
        mem[2] = 16'h0000;
        load_pc(AB'(0));
        run = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            check("t2_valid", 32'(instr_valid), 32'(c == 3 || c == 6 || c == 9));
            check("t2_pc_wr", 32'(pc_wr), 32'(c == 3 || c == 6));
            check("t2_halted", 32'(halted), 32'(c >= 10));
            if (c == 3 || c == 6 || c == 9) begin
                check("t2_opcode", 32'(opcode), exp_ops[c/3-1]);
                check("t2_operand", 32'(operand), exp_opr[c/3-1]);
            end
        end
        check("t2_retired", 32'(retired), 32'(3));
        do_reset();

        // run dropped during the second FETCH, then resume
        load_pc(AB'(16));
        run = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            tick();
            check("t3_rom_en", 32'(rom_en), 32'(c == 1 || c == 4));
            check("t3_valid", 32'(instr_valid), 32'(c == 3 || c == 6));
            check("t3_pc_wr", 32'(pc_wr), 32'(c == 3 || c == 6));
            if (c == 4) run = 1'b0;
        end
        check("t3_pc_after_stop", 32'(pc_addr), 32'(18));
        run = 1'b1;
        tick();
        check("t3_resume_en", 32'(rom_en), 32'(1));
        check("t3_resume_addr", 32'(rom_addr), 32'(18));
        run = 1'b0;
        repeat (4) tick();

        // PC wrap from the top of the ROM
        mem[11'h7FF] = 16'h0ABC;
        mem[0]       = 16'h0801;
        load_pc(AB'(11'h7FF));
        run = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (c == 3) begin
                check("t4_rom_addr_top", 32'(rom_addr), 32'h7FF);
                check("t4_pc_wr_top", 32'(pc_wr), 32'(1));
                check("t4_operand_top", 32'(operand), 32'h2BC);
            end
            if (c == 4) begin
                check("t4_wrap_fetch", 32'(rom_addr), 32'(0));
                run = 1'b0;
            end
            if (c == 6) begin
                check("t4_wrap_operand", 32'(operand), 32'h001);
                check("t4_wrap_rom_addr", 32'(rom_addr), 32'(0));
            end
        end

        // Reset while the ROM word is in flight
        run = 1'b1;
        tick();
        tick();
        do_reset();
        repeat (4) begin
            tick();
            check("t1_idle_rom_en", 32'(rom_en), 32'(0));
        end

        // HALT is final: run toggles and ROM noise change nothing
        mem[32] = 16'h0123;
        load_pc(AB'(32));
        run = 1'b1;
        repeat (4) tick();
        scramble = 1'b1;
        for (int c = 0; c < 12; c++) begin
            run = 1'($urandom);
            tick();
            check("t6_opcode", 32'(opcode), 32'(0));
            check("t6_operand", 32'(operand), 32'h123);
            check("t6_rom_addr", 32'(rom_addr), 32'(32));
            check("t6_halted", 32'(halted), 32'(1));
        end
        scramble = 1'b0;

        // Retire counter saturation
        do_reset();
        load_pc(AB'(48));
        force dut.retired = 16'hFFFE;
        exp_ret = 32'hFFFE;
        tick();
        release dut.retired;
        tick();
        run = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (c == 7) run = 1'b0;
        end
        check("t5_saturated", 32'(retired), 32'hFFFF);

        // Random programs with random run patterns
        for (int ep = 0; ep < 30; ep++) begin
            do_reset();
            for (int i = 0; i < (1 << AB); i++) begin
                op = ($urandom_range(0, 19) == 0) ? OPB'(0) : OPB'($urandom_range(1, 31));
                mem[i] = {op, AB'($urandom)};
            end
            load_pc(AB'($urandom));
            for (int c = 0; c < 160; c++) begin
                run = ($urandom_range(0, 9) != 0);
                tick();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
